// File: rtl/lif_neuron.sv
// Leaky integrate-and-fire neuron: shift leak, weighted spike integration,
// one-cycle output spike with reset-to-zero and a refractory hold-off.
module lif_neuron #(
  parameter int NUM_INPUTS     = 8,
  parameter int WEIGHT_W       = 8,
  parameter int POT_W          = 16,
  parameter int THRESHOLD      = 100,
  parameter int LEAK_SHIFT     = 4,
  parameter int REFRACTORY     = 2,
  parameter int DEFAULT_WEIGHT = 16,
  localparam int ADDR_W        = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [NUM_INPUTS-1:0] spike_in,
  input  logic                  cfg_we,
  input  logic [ADDR_W-1:0]     cfg_addr,
  input  logic [WEIGHT_W-1:0]   cfg_wdata,
  output logic                  spike_out,
  output logic [POT_W-1:0]      v_mem
);

  // Wide enough that leak, weight sum and potential never overflow together.
  localparam int INT_W = POT_W + ADDR_W + 2;
  localparam int REF_W = (REFRACTORY > 0) ? $clog2(REFRACTORY + 1) : 1;

  localparam logic signed [WEIGHT_W-1:0] W_DEF    = WEIGHT_W'(DEFAULT_WEIGHT);
  localparam logic        [POT_W-1:0]    THR      = POT_W'(THRESHOLD);
  localparam logic        [REF_W-1:0]    REF_LOAD = REF_W'(REFRACTORY);

  logic signed [WEIGHT_W-1:0] weight [NUM_INPUTS];
  logic        [REF_W-1:0]    refr_cnt;

  logic signed [INT_W-1:0]    sum_p0;
  logic signed [INT_W-1:0]    v_ext_p0;
  logic signed [INT_W-1:0]    leak_ext_p0;
  logic signed [INT_W-1:0]    v_int_p0;
  logic        [POT_W-1:0]    v_sat_p0;
  logic                       fire_p0;

  function automatic logic signed [INT_W-1:0] sext_w(input logic signed [WEIGHT_W-1:0] w);
    sext_w = {{(INT_W-WEIGHT_W){w[WEIGHT_W-1]}}, w};
  endfunction

  // Saturate the wide signed intermediate into the unsigned potential range.
  function automatic logic [POT_W-1:0] sat_pot(input logic signed [INT_W-1:0] x);
    if (x[INT_W-1])
      sat_pot = '0;
    else if (|x[INT_W-2:POT_W])
      sat_pot = '1;
    else
      sat_pot = x[POT_W-1:0];
  endfunction

  always_comb begin
    sum_p0 = '0;
    for (int i = 0; i < NUM_INPUTS; i++) begin
      if (spike_in[i])
        sum_p0 = sum_p0 + sext_w(weight[i]);
    end
  end

  assign v_ext_p0    = {{(INT_W-POT_W){1'b0}}, v_mem};
  assign leak_ext_p0 = {{(INT_W-POT_W){1'b0}}, (v_mem >> LEAK_SHIFT)};
  assign v_int_p0    = v_ext_p0 - leak_ext_p0 + sum_p0;
  assign v_sat_p0    = sat_pot(v_int_p0);
  assign fire_p0     = (v_sat_p0 >= THR);

  // Weights written this edge are only seen by integration from the next edge.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      for (int i = 0; i < NUM_INPUTS; i++)
        weight[i] <= W_DEF;
    end else if (cfg_we && (32'(cfg_addr) < NUM_INPUTS)) begin
      weight[cfg_addr] <= cfg_wdata;
    end
  end

  // ---- stage boundary: integrate / fire into membrane register ----
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      v_mem     <= '0;
      spike_out <= 1'b0;
      refr_cnt  <= '0;
    end else if (refr_cnt != '0) begin
      v_mem     <= '0;
      spike_out <= 1'b0;
      refr_cnt  <= refr_cnt - REF_W'(1);
    end else if (fire_p0) begin
      v_mem     <= '0;
      spike_out <= 1'b1;
      refr_cnt  <= REF_LOAD;
    end else begin
      v_mem     <= v_sat_p0;
      spike_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_lif_neuron.sv
// Directed bench for lif_neuron: expected spike/potential pairs are queued
// when each step is driven and compared after the integrating edge.
`timescale 1ns/1ps
module tb_lif_neuron;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  spike_in;
  logic        cfg_we;
  logic [2:0]  cfg_addr;
  logic [7:0]  cfg_wdata;
  logic        spike_out;
  logic [15:0] v_mem;

  int n_asserts = 0;
  int n_fail    = 0;

  typedef struct {
    string       tag;
    logic        spk;
    logic [15:0] v;
  } exp_t;

  exp_t sb[$];

  lif_neuron dut (
    .clk       (clk),
    .rstn      (rstn),
    .spike_in  (spike_in),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_wdata (cfg_wdata),
    .spike_out (spike_out),
    .v_mem     (v_mem)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus (optionally with a weight write), push the
  // expected post-edge state, then compare it just after the edge.
  task automatic step(input string tag, input logic [7:0] spk,
                      input logic exp_s, input logic [15:0] exp_v,
                      input logic we = 1'b0, input logic [2:0] addr = 3'd0,
                      input logic [7:0] wdata = 8'd0);
    exp_t e;
    e.tag = tag; e.spk = exp_s; e.v = exp_v;
    sb.push_back(e);
    spike_in  = spk;
    cfg_we    = we;
    cfg_addr  = addr;
    cfg_wdata = wdata;
    @(posedge clk);
    #1;
    cfg_we = 1'b0;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, "_spike"}, {31'd0, spike_out}, {31'd0, e.spk});
      check({e.tag, "_vmem"},  {16'd0, v_mem},     {16'd0, e.v});
    end
  endtask

  // Asynchronous reset pulse inside a cycle, checked before any clock edge.
  task automatic async_reset(input string tag);
    rstn = 1'b1;
    #1;
    check({tag, "_spike"}, {31'd0, spike_out}, 32'd0);
    check({tag, "_vmem"},  {16'd0, v_mem},     32'd0);
    #1;
    rstn = 1'b0;
  endtask

  initial begin
    logic [15:0] integ [7];
    integ = '{16'd16, 16'd31, 16'd46, 16'd60, 16'd73, 16'd85, 16'd96};

    rstn = 1'b1; spike_in = '0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_spike", {31'd0, spike_out}, 32'd0);
    check("reset_vmem",  {16'd0, v_mem},     32'd0);
    rstn = 1'b0;

    // Integrate and fire with default weights on synapse 0.
    for (int i = 0; i < 7; i++) step($sformatf("integ_e%0d", i + 1), 8'h01, 1'b0, integ[i]);
    step("fire_e8",  8'h01, 1'b1, 16'd0);
    step("refr_e9",  8'h01, 1'b0, 16'd0);
    step("refr_e10", 8'h01, 1'b0, 16'd0);
    step("resume_e11", 8'h01, 1'b0, 16'd16);

    // Leak only, starting from 96.
    for (int i = 1; i < 7; i++) step($sformatf("climb_%0d", i), 8'h01, 1'b0, integ[i]);
    step("leak_90", 8'h00, 1'b0, 16'd90);
    step("leak_85", 8'h00, 1'b0, 16'd85);
    step("leak_80", 8'h00, 1'b0, 16'd80);
    step("leak_75", 8'h00, 1'b0, 16'd75);

    // Leak floor: a potential of 15 does not decay.
    async_reset("rst_floor");
    step("wr_w0_15", 8'h00, 1'b0, 16'd0, 1'b1, 3'd0, 8'd15);
    step("floor_set", 8'h01, 1'b0, 16'd15);
    step("floor_hold1", 8'h00, 1'b0, 16'd15);
    step("floor_hold2", 8'h00, 1'b0, 16'd15);
    step("wr_w0_16", 8'h00, 1'b0, 16'd15, 1'b1, 3'd0, 8'd16);

    // All inputs at once fire in a single edge; refractory masks inputs.
    async_reset("rst_simul");
    step("simul_fire", 8'hFF, 1'b1, 16'd0);
    step("mask_1", 8'hFF, 1'b0, 16'd0);
    step("mask_2", 8'hFF, 1'b0, 16'd0);
    step("mask_resume", 8'h01, 1'b0, 16'd16);

    // Inhibitory weight drives potential to the zero clamp.
    step("wr_w1_neg", 8'h01, 1'b0, 16'd31, 1'b1, 3'd1, 8'h80);
    step("inh_46", 8'h01, 1'b0, 16'd46);
    step("inh_60", 8'h01, 1'b0, 16'd60);
    step("inh_clamp", 8'h02, 1'b0, 16'd0);
    // Write and spike on synapse 1 together: the old (-128) weight applies.
    step("same_cyc_old", 8'h02, 1'b0, 16'd0, 1'b1, 3'd1, 8'd16);
    step("same_cyc_new", 8'h02, 1'b0, 16'd32 - 16'd16);

    // Mid-run reset clears potential at once and restores default weights.
    step("pre_rst", 8'h01, 1'b0, 16'd31);
    async_reset("rst_midrun");
    step("rst_wdef", 8'h02, 1'b0, 16'd16);

    // Reset during refractory aborts it immediately.
    async_reset("rst_pre_refr");
    step("refr_fire", 8'hFF, 1'b1, 16'd0);
    async_reset("rst_in_refr");
    step("refr_abort", 8'h01, 1'b0, 16'd16);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule

// File: doc/lif_neuron.md
Name: lif_neuron

Overview:
- Single leaky integrate-and-fire neuron for the spiking-network datapath.
- Each cycle it applies a shift-based leak, adds the signed synaptic weights of active input spikes, fires a one-cycle output spike on crossing threshold, then resets and enters a refractory period.
- Per-synapse weights are runtime-programmable through a simple write port.
- Membrane potential is exported for monitoring.

Parameters:
- NUM_INPUTS, 8, number of synaptic inputs (width of spike_in)
- WEIGHT_W, 8, width of each signed two's-complement synaptic weight
- POT_W, 16, width of unsigned membrane potential
- THRESHOLD, 100, firing threshold (fire when potential >= THRESHOLD)
- LEAK_SHIFT, 4, per-cycle leak equals potential >> LEAK_SHIFT
- REFRACTORY, 2, cycles after a spike during which inputs are ignored
- DEFAULT_WEIGHT, 16, value loaded into every weight on reset

Ports:
- clk  in  1  rising-edge clock
- rstn  in  1  asynchronous reset, active-HIGH despite the name
- spike_in  in  NUM_INPUTS  input spike per synapse, sampled each rising edge
- cfg_we  in  1  weight write enable
- cfg_addr  in  clog2(NUM_INPUTS)  synapse index to write
- cfg_wdata  in  WEIGHT_W  signed weight value
- spike_out  out  1  registered output spike, high for exactly one cycle per firing
- v_mem  out  POT_W  current membrane potential (register value)

Behaviour:
- Reset (rstn=1, async): v_mem=0, spike_out=0, refractory counter=0, all weights=DEFAULT_WEIGHT. Reset mid-operation aborts any refractory period immediately.
- Weight write: on an edge with cfg_we=1, weight[cfg_addr]<=cfg_wdata. cfg_addr >= NUM_INPUTS is ignored. A write in the same cycle as a spike on that synapse uses the old weight; the new weight applies from the next edge.
- Normal cycle (refractory counter = 0):
  - sum = signed sum of weight[i] over all i with spike_in[i]=1.
  - v_int = v_mem - (v_mem >> LEAK_SHIFT) + sum, computed in signed width POT_W + clog2(NUM_INPUTS) + 2 (no overflow).
  - Clamp v_int to [0, 2^POT_W - 1].
  - If clamped v_int >= THRESHOLD: spike_out<=1, v_mem<=0, refractory counter<=REFRACTORY.
  - Otherwise: spike_out<=0, v_mem<=clamped v_int.
- Refractory cycle (counter > 0): spike_in ignored, v_mem held at 0, spike_out<=0, counter decrements by 1.
- Latency: spike_out rises on the same edge that integrates the crossing input, i.e. one clock after the input is presented.
- Leak floor: for v_mem < 2^LEAK_SHIFT the leak is 0, so the potential holds constant. This is intended.
- spike_out is never high on two consecutive cycles when REFRACTORY >= 1. With REFRACTORY=0, back-to-back firing is permitted.

Test Plan:
- Reset: assert rstn=1 mid-run -> spike_out=0 and v_mem=0 immediately (asynchronous); weights read back as 16 via behaviour in the next test.
- Integrate and fire: defaults, spike_in=8'h01 held every cycle.
  - v_mem after edges 1..7 = 16, 31, 46, 60, 73, 85, 96.
  - Edge 8 -> spike_out=1 for one cycle, v_mem=0.
  - Edges 9-10 (refractory) -> v_mem=0.
  - Edge 11 -> v_mem=16.
- Leak only: bring v_mem to 96, then spike_in=0 -> v_mem 90, 85, 80, 75 on successive edges; a potential of 15 with no input stays 15.
- Simultaneous inputs: from v_mem=0, spike_in=8'hFF with all weights 16 (sum 128) -> spike_out=1 after a single edge, v_mem=0.
- Inhibition and clamp:
  - Write weight[1]=-128 (8'h80) via cfg port.
  - At v_mem=60 apply spike_in=8'h02 -> v_mem clamps to 0, no spike.
  - Same-cycle write+spike on synapse 1 uses the old weight.
- Refractory masking: during both refractory cycles apply spike_in=8'hFF -> v_mem stays 0 and spike_out stays 0; integration resumes on the third post-spike edge.
